// File: rtl/ldlt_pkg.sv
// Shared definitions for the LDLT solver output path: default sizing of the
// packed lower-triangular factor and the result collector state encoding.
package ldlt_pkg;

   // Address width helper that never returns zero, so one-word buffers still get a 1-bit index
   function automatic int idx_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   localparam int DATA_LEN = 32;
   localparam int NODE_NUM = 16;
   localparam int DIM      = 6 * NODE_NUM;
   localparam int L_SIZE   = DIM * (DIM + 1) / 2;
   localparam int IDX_W    = idx_width(L_SIZE);
   localparam int RC_W     = idx_width(DIM);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      READY   = 2'd2
   } collector_state_t;

endpackage

// File: rtl/ldlt_tri_index.sv
// Maps a (row, col) coordinate of the symmetric matrix onto the row-major
// packed lower-triangle index r*(r+1)/2 + c, folding the upper triangle onto
// the lower one. Purely combinational.
module ldlt_tri_index #(
   parameter int DIM    = 6,
   parameter int RC_W   = 3,
   parameter int IDX_W  = 5,
   parameter int L_SIZE = 21
) (
   input  logic [RC_W-1:0]  row,
   input  logic [RC_W-1:0]  col,
   output logic [IDX_W-1:0] idx,
   output logic             out_of_range
);

   logic [RC_W-1:0] hi;
   logic [RC_W-1:0] lo;
   logic [IDX_W:0]  hi_ext;
   logic [IDX_W:0]  lo_ext;
   logic [IDX_W:0]  prod;
   logic [IDX_W:0]  idx_full;

   // Swap into the lower triangle, then form the triangular number; the product is always even so the halving is a plain shift
   always_comb begin
      hi = row;
      lo = col;
      if (col > row) begin
         hi = col;
         lo = row;
      end
      hi_ext   = (IDX_W+1)'(hi);
      lo_ext   = (IDX_W+1)'(lo);
      prod     = hi_ext * (hi_ext + (IDX_W+1)'(1));
      idx_full = (prod >> 1) + lo_ext;
      out_of_range = ((RC_W+1)'(row) >= (RC_W+1)'(DIM)) ||
                     ((RC_W+1)'(col) >= (RC_W+1)'(DIM)) ||
                     (idx_full >= (IDX_W+1)'(L_SIZE));
      idx = out_of_range ? '0 : idx_full[IDX_W-1:0];
   end

endmodule

// File: rtl/ldlt_result_collector.sv
// Captures one gapless burst of the packed L factor from the solver into a
// local buffer, then serves (row, col) random-access reads with a fixed
// two-cycle latency. A clear pulse discards the buffer and re-arms capture.
module ldlt_result_collector #(
   parameter  int DATA_LEN = ldlt_pkg::DATA_LEN,
   parameter  int NODE_NUM = ldlt_pkg::NODE_NUM,
   localparam int DIM      = 6 * NODE_NUM,
   localparam int L_SIZE   = DIM * (DIM + 1) / 2,
   localparam int IDX_W    = ldlt_pkg::idx_width(L_SIZE),
   localparam int RC_W     = ldlt_pkg::idx_width(DIM)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   input  logic [DATA_LEN-1:0] s_data,
   input  logic                i_clear,
   input  logic                rd_req,
   input  logic [RC_W-1:0]     rd_row,
   input  logic [RC_W-1:0]     rd_col,
   output logic                rd_ack,
   output logic [DATA_LEN-1:0] rd_data,
   output logic                rd_err,
   output logic                o_busy,
   output logic                o_done
);

   import ldlt_pkg::*;

   collector_state_t state;
   collector_state_t state_next;

   logic [IDX_W-1:0]    cnt;
   logic                last_word;
   logic                wr_en;
   logic [IDX_W-1:0]    wr_addr;
   logic [DATA_LEN-1:0] mem [L_SIZE];

   logic [IDX_W-1:0]    rd_idx;
   logic                rd_oor;
   logic                s1_valid;
   logic                s1_err;
   logic [IDX_W-1:0]    s1_idx;
   logic                rd_ok;
   logic [DATA_LEN-1:0] mem_q;

   assign last_word = (cnt == IDX_W'(L_SIZE - 1));

   ldlt_tri_index #(
      .DIM    (DIM),
      .RC_W   (RC_W),
      .IDX_W  (IDX_W),
      .L_SIZE (L_SIZE)
   ) u_tri_index (
      .row          (rd_row),
      .col          (rd_col),
      .idx          (rd_idx),
      .out_of_range (rd_oor)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: arm on first valid word, finish after the last packed word, clear aborts or releases the buffer
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (s_valid) begin
               state_next = (L_SIZE == 1) ? READY : CAPTURE;
            end
         end
         CAPTURE: begin
            if (i_clear) begin
               state_next = IDLE;
            end else if (last_word) begin
               state_next = READY;
            end
         end
         READY: begin
            if (i_clear) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs and buffer write-port control
   always_comb begin
      o_busy  = 1'b0;
      o_done  = 1'b0;
      wr_en   = 1'b0;
      wr_addr = cnt;
      case (state)
         IDLE: begin
            wr_en   = s_valid;
            wr_addr = '0;
         end
         CAPTURE: begin
            o_busy = 1'b1;
            wr_en  = !i_clear;
         end
         READY: begin
            o_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Word counter: points at the next buffer address to fill during capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == IDLE) begin
         cnt <= s_valid ? IDX_W'(1) : '0;
      end else if (state == CAPTURE) begin
         if (i_clear || last_word) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + IDX_W'(1);
         end
      end
   end

   // Buffer write port, owned by capture; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= s_data;
      end
   end

   // Read stage 1: register the request, packed index and error decision; a same-cycle clear swallows the request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_idx   <= '0;
      end else begin
         s1_valid <= rd_req && !i_clear;
         s1_err   <= rd_oor || (state != READY);
         s1_idx   <= rd_idx;
      end
   end

   // Buffer read port, synchronous, owned by the host
   always_ff @(posedge clk) begin
      mem_q <= mem[s1_idx];
   end

   // Read stage 2: response strobe and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ack <= 1'b0;
         rd_err <= 1'b0;
         rd_ok  <= 1'b0;
      end else begin
         rd_ack <= s1_valid;
         rd_err <= s1_valid && s1_err;
         rd_ok  <= s1_valid && !s1_err;
      end
   end

   assign rd_data = rd_ok ? mem_q : '0;

endmodule
